ahb_matrix_out_arb: RTL and testbench

//  Parametrised output-stage arbiter for the AHB bus matrix, one instance per slave port.

---
 rtl/ahb_matrix_out_arb.sv | 158 +++++++++++++++
 tb/tb_ahb_matrix_out_arb.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/ahb_matrix_out_arb.sv
// Output-stage arbiter for one AHB bus-matrix slave port: fixed-priority or round-robin grant.
// Optional burst hold is compiled in with `define AHB_ARB_BURST_HOLD_EN.
module ahb_matrix_out_arb #(
    parameter int NUM_PORTS = 5,
    parameter int PORT_W    = 3,
    parameter int ARB_MODE  = 0
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,
    input  logic [NUM_PORTS-1:0] req_port,
    input  logic                 HREADYM,
    input  logic                 HSELM,
    input  logic [1:0]           HTRANSM,
    input  logic [2:0]           HBURSTM,
    input  logic                 HMASTLOCKM,
    output logic [PORT_W-1:0]    addr_in_port,
    output logic                 no_port
);

    localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;
    localparam logic [1:0] TRANS_SEQ    = 2'b11;

    logic [PORT_W-1:0]    addr_r;
    logic                 no_port_r;
    logic [PORT_W-1:0]    rr_last_r;
    logic [NUM_PORTS-1:0] eff_s;
    logic                 cur_active_s;
    logic [PORT_W-1:0]    win_s;
    logic [PORT_W-1:0]    addr_next_s;
    logic                 no_port_next_s;
    logic [PORT_W-1:0]    rr_next_s;
    logic                 hold_s;

    assign cur_active_s = HSELM & (HTRANSM != TRANS_IDLE);

    // The port currently owning the bus keeps requesting while its transfer is live.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_eff
            assign eff_s[gi] = req_port[gi] | (cur_active_s & (addr_r == PORT_W'(gi)));
        end
    endgenerate

`ifdef AHB_ARB_BURST_HOLD_EN
    logic [4:0] beat_cnt_r;
    logic [4:0] beat_cnt_next_s;

    function automatic logic [4:0] burst_beats(input logic [2:0] hburst);
        logic [4:0] beats;
        case (hburst)
            3'b010, 3'b011: beats = 5'd3;
            3'b100, 3'b101: beats = 5'd7;
            3'b110, 3'b111: beats = 5'd15;
            default:        beats = 5'd0;
        endcase
        return beats;
    endfunction

    // Remaining SEQ beats after the current one; hold on the post-update count so the
    // NONSEQ beat already protects the burst and the last SEQ beat releases the slave.
    always_comb begin
        beat_cnt_next_s = beat_cnt_r;
        if (!HSELM || (HTRANSM == TRANS_IDLE)) begin
            beat_cnt_next_s = 5'd0;
        end else if (HTRANSM == TRANS_NONSEQ) begin
            beat_cnt_next_s = burst_beats(HBURSTM);
        end else if ((HTRANSM == TRANS_SEQ) && (beat_cnt_r != 5'd0)) begin
            beat_cnt_next_s = beat_cnt_r - 5'd1;
        end else begin
            beat_cnt_next_s = beat_cnt_r;
        end
    end

    assign hold_s = (beat_cnt_next_s != 5'd0);

    // Beat counter register, advanced only on completed beats.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            beat_cnt_r <= 5'd0;
        end else if (HREADYM) begin
            beat_cnt_r <= beat_cnt_next_s;
        end
    end
`else
    logic unused_burst_s;
    assign unused_burst_s = ^HBURSTM;
    assign hold_s         = 1'b0;
`endif

    // Winner search; the loops run in reverse so the last hit is the highest-priority one.
    always_comb begin
        int idx;
        win_s = addr_r;
        idx   = 0;
        if (ARB_MODE == 0) begin
            for (int i = NUM_PORTS - 1; i >= 0; i--) begin
                if (eff_s[IDX_W'(i)]) begin
                    win_s = PORT_W'(i);
                end else begin
                    win_s = win_s;
                end
            end
        end else begin
            for (int k = NUM_PORTS; k >= 1; k--) begin
                idx = int'(rr_last_r) + k;
                if (idx >= NUM_PORTS) begin
                    idx = idx - NUM_PORTS;
                end else begin
                    idx = idx;
                end
                if (eff_s[IDX_W'(idx)]) begin
                    win_s = PORT_W'(idx);
                end else begin
                    win_s = win_s;
                end
            end
        end
    end

    // Grant decision: lock, burst hold, arbitration, slave still selected, idle.
    always_comb begin
        addr_next_s    = addr_r;
        no_port_next_s = 1'b1;
        rr_next_s      = rr_last_r;
        if (HMASTLOCKM) begin
            no_port_next_s = 1'b0;
        end else if (hold_s) begin
            no_port_next_s = 1'b0;
        end else if (|eff_s) begin
            addr_next_s    = win_s;
            no_port_next_s = 1'b0;
            rr_next_s      = win_s;
        end else if (HSELM) begin
            no_port_next_s = 1'b0;
        end else begin
            no_port_next_s = 1'b1;
        end
    end

    // Grant state registers; everything freezes while the slave stretches a beat.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            addr_r    <= '0;
            no_port_r <= 1'b1;
            rr_last_r <= PORT_W'(NUM_PORTS - 1);
        end else if (HREADYM) begin
            addr_r    <= addr_next_s;
            no_port_r <= no_port_next_s;
            rr_last_r <= rr_next_s;
        end
    end

    assign addr_in_port = addr_r;
    assign no_port      = no_port_r;

endmodule

// File: tb/tb_ahb_matrix_out_arb.sv
// Scoreboard bench: one fixed-priority and one round-robin arbiter share the stimulus.
// Define AHB_ARB_BURST_HOLD_EN to add the burst-hold vectors.
module tb_ahb_matrix_out_arb;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic       rdy;
    logic       sel;
    logic [1:0] trans;
    logic [2:0] burst;
    logic       lock;
    logic [1:0] addr_f;
    logic       np_f;
    logic [1:0] addr_r;
    logic       np_r;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      name;
        logic [1:0] af;
        logic       nf;
        logic [1:0] ar;
        logic       nr;
    } exp_t;

    exp_t exp_q[$];

    ahb_matrix_out_arb #(.NUM_PORTS(4), .PORT_W(2), .ARB_MODE(0)) dut_fp (
        .HCLK(clk), .HRESETn(rst_n), .req_port(req), .HREADYM(rdy), .HSELM(sel),
        .HTRANSM(trans), .HBURSTM(burst), .HMASTLOCKM(lock),
        .addr_in_port(addr_f), .no_port(np_f)
    );

    ahb_matrix_out_arb #(.NUM_PORTS(4), .PORT_W(2), .ARB_MODE(1)) dut_rr (
        .HCLK(clk), .HRESETn(rst_n), .req_port(req), .HREADYM(rdy), .HSELM(sel),
        .HTRANSM(trans), .HBURSTM(burst), .HMASTLOCKM(lock),
        .addr_in_port(addr_r), .no_port(np_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [1:0] ga, input logic gn,
                       input logic [1:0] ea, input logic en);
        checks++;
        if (ga !== ea || gn !== en) begin
            errors++;
            $display("FAIL %s: got addr=%0d no_port=%0b, expected addr=%0d no_port=%0b",
                     nm, ga, gn, ea, en);
        end
    endtask

    // Drive one vector at the falling edge; expectations refer to the next rising edge.
    task automatic run(input string nm, input logic [3:0] r, input logic rd, input logic s,
                       input logic [1:0] t, input logic [2:0] b, input logic lk,
                       input logic [1:0] af, input logic nf, input logic [1:0] ar,
                       input logic nr);
        exp_t e;
        @(negedge clk);
        req = r; rdy = rd; sel = s; trans = t; burst = b; lock = lk;
        e.name = nm; e.af = af; e.nf = nf; e.ar = ar; e.nr = nr;
        exp_q.push_back(e);
    endtask

    // Monitor: after each rising edge, compare both arbiters against the oldest expectation.
    always begin
        exp_t e;
        @(posedge clk);
        #2;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({e.name, "_fp"}, addr_f, np_f, e.af, e.nf);
            chk({e.name, "_rr"}, addr_r, np_r, e.ar, e.nr);
        end
    end

    initial begin
        rst_n = 1'b0; req = 4'b0000; rdy = 1'b1; sel = 1'b0;
        trans = 2'b00; burst = 3'b000; lock = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("reset_fp", addr_f, np_f, 2'd0, 1'b1);
        chk("reset_rr", addr_r, np_r, 2'd0, 1'b1);

        //   name            req      rdy   sel   trn    bur     lk    af    nf    ar    nr
        run("idle",        4'b0000, 1'b1, 1'b0, 2'b00, 3'b000, 1'b0, 2'd0, 1'b1, 2'd0, 1'b1);
        run("all_req1",    4'b1111, 1'b1, 1'b0, 2'b00, 3'b000, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
        run("all_req2",    4'b1111, 1'b1, 1'b0, 2'b00, 3'b000, 1'b0, 2'd0, 1'b0, 2'd1, 1'b0);
        run("all_req3",    4'b1111, 1'b1, 1'b0, 2'b00, 3'b000, 1'b0, 2'd0, 1'b0, 2'd2, 1'b0);
        run("all_req4",    4'b1111, 1'b1, 1'b0, 2'b00, 3'b000, 1'b0, 2'd0, 1'b0, 2'd3, 1'b0);
        run("all_req5",    4'b1111, 1'b1, 1'b0, 2'b00, 3'b000, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
        run("req_1010",    4'b1010, 1'b1, 1'b0, 2'b00, 3'b000, 1'b0, 2'd1, 1'b0, 2'd1, 1'b0);
        run("no_req",      4'b0000, 1'b1, 1'b0, 2'b00, 3'b000, 1'b0, 2'd1, 1'b1, 2'd1, 1'b1);
        run("hsel_idle",   4'b0000, 1'b1, 1'b1, 2'b00, 3'b000, 1'b0, 2'd1, 1'b0, 2'd1, 1'b0);
        run("cur_active",  4'b0000, 1'b1, 1'b1, 2'b10, 3'b000, 1'b0, 2'd1, 1'b0, 2'd1, 1'b0);
        run("grant2",      4'b0100, 1'b1, 1'b0, 2'b00, 3'b000, 1'b0, 2'd2, 1'b0, 2'd2, 1'b0);
        run("lock1",       4'b0001, 1'b1, 1'b1, 2'b10, 3'b000, 1'b1, 2'd2, 1'b0, 2'd2, 1'b0);
        run("lock2",       4'b0001, 1'b1, 1'b1, 2'b10, 3'b000, 1'b1, 2'd2, 1'b0, 2'd2, 1'b0);
        run("lock_drop",   4'b0001, 1'b1, 1'b1, 2'b10, 3'b000, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
        run("frozen1",     4'b0100, 1'b0, 1'b0, 2'b00, 3'b000, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
        run("frozen2",     4'b0100, 1'b0, 1'b0, 2'b00, 3'b000, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
        run("unfrozen",    4'b0100, 1'b1, 1'b0, 2'b00, 3'b000, 1'b0, 2'd2, 1'b0, 2'd2, 1'b0);
        run("rr_from3",    4'b1111, 1'b1, 1'b0, 2'b00, 3'b000, 1'b0, 2'd0, 1'b0, 2'd3, 1'b0);
        run("rr_wrap",     4'b1010, 1'b1, 1'b0, 2'b00, 3'b000, 1'b0, 2'd1, 1'b0, 2'd1, 1'b0);

        // Asynchronous reset between clock edges, with a grant in place.
        @(negedge clk);
        req = 4'b1111;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_fp", addr_f, np_f, 2'd0, 1'b1);
        chk("async_rst_rr", addr_r, np_r, 2'd0, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        req   = 4'b0000;
        run("rr_after_rst", 4'b1111, 1'b1, 1'b0, 2'b00, 3'b000, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0);

`ifdef AHB_ARB_BURST_HOLD_EN
        run("b_grant3",    4'b1000, 1'b1, 1'b0, 2'b00, 3'b000, 1'b0, 2'd3, 1'b0, 2'd3, 1'b0);
        run("b_nonseq",    4'b0001, 1'b1, 1'b1, 2'b10, 3'b011, 1'b0, 2'd3, 1'b0, 2'd3, 1'b0);
        run("b_seq1",      4'b0001, 1'b1, 1'b1, 2'b11, 3'b011, 1'b0, 2'd3, 1'b0, 2'd3, 1'b0);
        run("b_seq2",      4'b0001, 1'b1, 1'b1, 2'b11, 3'b011, 1'b0, 2'd3, 1'b0, 2'd3, 1'b0);
        run("b_seq3",      4'b0001, 1'b1, 1'b1, 2'b11, 3'b011, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
        run("e_grant3",    4'b1000, 1'b1, 1'b0, 2'b00, 3'b000, 1'b0, 2'd3, 1'b0, 2'd3, 1'b0);
        run("e_nonseq",    4'b0001, 1'b1, 1'b1, 2'b10, 3'b011, 1'b0, 2'd3, 1'b0, 2'd3, 1'b0);
        run("e_seq1",      4'b0001, 1'b1, 1'b1, 2'b11, 3'b011, 1'b0, 2'd3, 1'b0, 2'd3, 1'b0);
        run("e_idle",      4'b0001, 1'b1, 1'b1, 2'b00, 3'b011, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
`endif

        for (int n = 0; n < 20 && exp_q.size() > 0; n++) begin
            @(negedge clk);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
